// File: rtl/speed_pkg.sv
// speed_pkg: shared key-FSM types and default rate constants for speed_ctrl
package speed_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, BLOCKED} state_t;
  typedef enum logic {UP, DOWN} dir_t;
  localparam int unsigned DEF_COUNT = 3472;
  localparam int unsigned DEF_STEP = 10;
  localparam int unsigned DEF_MIN = 1736;
  localparam int unsigned DEF_MAX = 6944;
endpackage

// File: rtl/speed_ctrl_sample_divider.sv
// sample_divider: one-cycle strobe every count_to cycles, restarting at once if count_to drops below the count
module sample_divider #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_to,
  output logic             sample_tick
);
  logic [CNT_W-1:0] div_cnt;
  always_ff @(posedge clk)
    if (reset) begin
      div_cnt <= '0;
      sample_tick <= 1'b0;
    end else if (div_cnt >= count_to - CNT_W'(1)) begin
      div_cnt <= '0;
      sample_tick <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
      sample_tick <= 1'b0;
    end
endmodule

// File: rtl/speed_ctrl.sv
// speed_ctrl: key-driven saturating playback-rate count with first-press/auto-repeat events and sample strobe
module speed_ctrl
  import speed_pkg::*;
#(
  parameter int          CNT_W         = 32,
  parameter int unsigned DEFAULT_COUNT = DEF_COUNT,
  parameter int unsigned STEP          = DEF_STEP,
  parameter int unsigned MIN_COUNT     = DEF_MIN,
  parameter int unsigned MAX_COUNT     = DEF_MAX,
  parameter int unsigned REPEAT_DELAY  = 12_500_000,
  parameter int unsigned REPEAT_RATE   = 2_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_reset,
  output logic [CNT_W-1:0] count_to,
  output logic             sample_tick,
  output logic             at_min,
  output logic             at_max
);
  localparam logic [CNT_W-1:0] C_DEF = CNT_W'(DEFAULT_COUNT);
  localparam logic [CNT_W-1:0] C_STEP = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] C_MIN = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_COUNT);
  state_t state;
  dir_t dir;
  logic [31:0] timer;
  logic [CNT_W-1:0] up_val, down_val;
  logic held, opp, fire;
  always_comb begin
    up_val = (count_to < C_MIN + C_STEP) ? C_MIN : count_to - C_STEP;
    down_val = (count_to > C_MAX - C_STEP) ? C_MAX : count_to + C_STEP;
    held = (dir == UP) ? key_up : key_down;
    opp = (dir == UP) ? key_down : key_up;
    fire = timer == ((state == DELAY) ? REPEAT_DELAY - 32'd1 : REPEAT_RATE - 32'd1);
  end
  always_ff @(posedge clk)
    if (reset) begin
      count_to <= C_DEF;
      state <= IDLE;
      dir <= UP;
      timer <= '0;
    end else if (key_reset) begin
      count_to <= C_DEF;
      state <= BLOCKED;
      timer <= '0;
    end else if (key_up && key_down) begin
      state <= BLOCKED;
      timer <= '0;
    end else begin
      case (state)
        IDLE:
          if (key_up || key_down) begin
            dir <= key_up ? UP : DOWN;
            count_to <= key_up ? up_val : down_val;
            timer <= '0;
            state <= DELAY;
          end
        DELAY, REPEAT:
          if (opp) state <= BLOCKED;
          else if (!held) state <= IDLE;
          else if (fire) begin
            count_to <= (dir == UP) ? up_val : down_val;
            timer <= '0;
            state <= REPEAT;
          end else timer <= timer + 32'd1;
        default:
          if (!key_up && !key_down) state <= IDLE;
      endcase
    end
  sample_divider #(.CNT_W(CNT_W)) u_div (
    .clk(clk),
    .reset(reset),
    .count_to(count_to),
    .sample_tick(sample_tick)
  );
  assign at_min = count_to == C_MIN;
  assign at_max = count_to == C_MAX;
endmodule

// File: tb/tb_speed_ctrl.sv
// tb_speed_ctrl: randomized and directed key stimulus checked against a hold-age behavioural model
module tb_speed_ctrl;
  localparam int RD = 20, RR = 5, DEF = 3472, STEP = 10, MINC = 1736, MAXC = 6944;
  logic clk = 1'b0, reset = 1'b1, key_up = 1'b0, key_down = 1'b0, key_reset = 1'b0;
  logic [31:0] count_to;
  logic sample_tick, at_min, at_max;
  logic s_rst = 1'b1, s_up = 1'b0, s_down = 1'b0, s_kr = 1'b0;
  int compared = 0, mismatched = 0;
  int m_cnt = DEF, m_div = 0, m_age = 0;
  bit m_tick = 0, m_hold = 0, m_blk = 0, m_dir_up = 0;
  int ticks[$];
  bit found;
  speed_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset), .key_up(key_up), .key_down(key_down), .key_reset(key_reset),
    .count_to(count_to), .sample_tick(sample_tick), .at_min(at_min), .at_max(at_max)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    s_rst <= reset;
    s_up <= key_up;
    s_down <= key_down;
    s_kr <= key_reset;
  end
  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step_rate(input bit up);
    m_cnt = up ? ((m_cnt - STEP > MINC) ? m_cnt - STEP : MINC) : ((m_cnt + STEP < MAXC) ? m_cnt + STEP : MAXC);
  endtask
  // Model: a press fires at hold age 0, again at age RD, then every RR cycles after that
  task automatic model_step();
    if (s_rst) begin
      m_cnt = DEF; m_div = 0; m_tick = 0; m_hold = 0; m_blk = 0; m_age = 0;
    end else begin
      m_tick = m_div >= m_cnt - 1;
      m_div = m_tick ? 0 : m_div + 1;
      if (s_kr) begin
        m_cnt = DEF; m_blk = 1; m_hold = 0;
      end else if (s_up && s_down) begin
        m_blk = 1; m_hold = 0;
      end else if (m_blk) m_blk = s_up || s_down;
      else if (m_hold) begin
        if (m_dir_up ? s_down : s_up) begin
          m_blk = 1; m_hold = 0;
        end else if (!(m_dir_up ? s_up : s_down)) m_hold = 0;
        else begin
          m_age++;
          if (m_age >= RD && (m_age - RD) % RR == 0) step_rate(m_dir_up);
        end
      end else if (s_up || s_down) begin
        m_hold = 1; m_dir_up = s_up; m_age = 0; step_rate(s_up);
      end
    end
  endtask
  always @(negedge clk) begin
    model_step();
    chk("count_to", count_to, m_cnt);
    chk("sample_tick", sample_tick, m_tick);
    chk("at_min", at_min, m_cnt == MINC);
    chk("at_max", at_max, m_cnt == MAXC);
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic keys(input logic u, input logic d, input logic r, input int n);
    key_up = u; key_down = d; key_reset = r;
    cyc(n);
  endtask
  initial begin
    cyc(3);
    reset = 1'b0;
    chk("reset_count", count_to, DEF);
    chk("reset_flags", {at_min, at_max, sample_tick}, 0);
    for (int n = 1; n <= 10420; n++) begin
      cyc(1);
      if (sample_tick) ticks.push_back(n);
    end
    chk("tick_count", ticks.size(), 3);
    for (int i = 0; i < ticks.size() && i < 3; i++) chk("tick_cycle", ticks[i], DEF * (i + 1));
    keys(1, 0, 0, 1);
    keys(0, 0, 0, 5);
    chk("single_press", count_to, 3462);
    keys(0, 0, 1, 1);
    keys(0, 0, 0, 1);
    keys(1, 0, 0, 31);
    keys(0, 0, 0, 5);
    chk("hold31", count_to, 3432);
    keys(0, 1, 0, 2000);
    chk("sat_max", count_to, MAXC);
    chk("at_max_lit", at_max, 1);
    keys(0, 0, 0, 2);
    keys(1, 0, 0, 3000);
    chk("sat_min", count_to, MINC);
    chk("at_min_lit", at_min, 1);
    keys(0, 0, 1, 1);
    keys(0, 0, 0, 1);
    keys(1, 0, 0, 22);
    keys(1, 1, 0, 10);
    keys(1, 0, 0, 30);
    chk("blocked_hold", count_to, 3452);
    keys(0, 0, 0, 1);
    keys(1, 0, 0, 1);
    chk("fresh_press", count_to, 3442);
    keys(0, 0, 0, 2);
    keys(1, 0, 0, 30);
    keys(1, 0, 1, 1);
    chk("kreset_in_repeat", count_to, DEF);
    keys(1, 0, 0, 10);
    chk("blocked_after_kreset", count_to, DEF);
    keys(0, 0, 0, 2);
    key_up = 1'b1;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("reset_mid_hold", count_to, 3462);
    keys(0, 0, 0, 2);
    found = 0;
    for (int n = 0; n < 8000 && !found; n++) begin
      cyc(1);
      found = m_div == m_cnt - 3;
    end
    chk("div_align_found", found, 1);
    if (found) begin
      keys(1, 0, 0, 1);
      keys(0, 0, 0, 1);
      chk("drop_tick", sample_tick, 1);
    end
    keys(0, 0, 0, 2);
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) key_up = ~key_up;
      else if (r < 8) key_down = ~key_down;
      key_reset = r == 8;
      cyc(1);
    end
    keys(0, 0, 0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/speed_ctrl.md
Name: speed_ctrl

Overview:
- Playback-rate controller for the audio sample clock. Converts held speed keys into rate-change events, with first-press and auto-repeat behaviour.
- Maintains a saturating divider terminal count, count_to, and generates the one-cycle sample_tick strobe that paces the audio read/output path.
- Sits between the synchronized key inputs and the flash-read / audio-output FSMs. Default rate is 7200 Hz at 25 MHz (count 3472).

Parameters:
- CNT_W, 32, width of count_to and of the divider counter.
- DEFAULT_COUNT, 3472, count_to value after reset or key_reset (7200 Hz).
- STEP, 10, change applied to count_to per speed event.
- MIN_COUNT, 1736, lower clamp on count_to (fastest rate).
- MAX_COUNT, 6944, upper clamp on count_to (slowest rate).
- REPEAT_DELAY, 12_500_000, cycles a key is held after the first event before auto-repeat starts.
- REPEAT_RATE, 2_500_000, cycles between auto-repeat events.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_up  in  1  speed-up request, already synchronized/debounced level, active-high
- key_down  in  1  slow-down request, synchronized level, active-high
- key_reset  in  1  restore default rate, synchronized level, active-high
- count_to  out  CNT_W  current divider terminal count (registered)
- sample_tick  out  1  one-cycle pulse, period = count_to cycles (registered)
- at_min  out  1  count_to == MIN_COUNT (combinational decode)
- at_max  out  1  count_to == MAX_COUNT (combinational decode)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset values: count_to = DEFAULT_COUNT, sample_tick = 0, divider = 0, FSM = IDLE, repeat timer = 0.
- Priority, evaluated every cycle: key_reset > everything.
  - While key_reset = 1: count_to <= DEFAULT_COUNT at each edge, FSM forced to BLOCKED, no up/down events.
- Up and down together: key_up and key_down both high means no event. FSM goes to BLOCKED.
- FSM states: IDLE, DELAY, REPEAT, BLOCKED. A dir register records UP or DOWN.
  - IDLE: exactly one of key_up/key_down high. Apply one event at that edge (count_to visible next cycle, i.e. 1-edge latency), latch dir, clear timer, go to DELAY.
  - DELAY: held key still high and timer reaches REPEAT_DELAY-1. Apply event, clear timer, go to REPEAT.
  - REPEAT: timer reaches REPEAT_RATE-1. Apply event, clear timer, stay in REPEAT.
  - DELAY or REPEAT: held key released goes to IDLE with no event. Opposite key asserted goes to BLOCKED.
  - BLOCKED: no events. Go to IDLE only when key_up, key_down and key_reset are all low.
- Up event: count_to <= (count_to < MIN_COUNT+STEP) ? MIN_COUNT : count_to - STEP.
- Down event: count_to <= (count_to > MAX_COUNT-STEP) ? MAX_COUNT : count_to + STEP.
- No wrap-around in either direction. Events at a clamp leave count_to unchanged, and the FSM keeps sequencing normally.
- Divider:
  - div_cnt increments each cycle.
  - When div_cnt >= count_to-1: sample_tick <= 1 for one cycle, div_cnt <= 0.
  - The >= comparison makes a mid-period drop of count_to below div_cnt produce an immediate tick and restart (no long wrap).
  - First tick: on the count_to-th rising edge after reset deasserts.
- Reset mid-hold: returns to reset values. A key still held after reset is treated as a new press only after the FSM reaches IDLE, which is immediate if only that key is high.

Decomposition:
- Shared package speed_pkg holds:
  - state enum (IDLE, DELAY, REPEAT, BLOCKED), dir enum (UP, DOWN)
  - DEFAULT_COUNT 3472 and the clamp constants
- One natural sub-module: sample_divider (count_to in, sample_tick out), reusable for other rate strobes. Key FSM and clamp arithmetic stay in speed_ctrl.

Test Plan (bench overrides REPEAT_DELAY = 20, REPEAT_RATE = 5):
- Reset, no keys -> count_to = 3472; sample_tick pulses at cycles 3472, 6944, 10416 after reset release; at_min = at_max = 0.
- key_up high for 1 cycle -> count_to = 3462 one edge later, no further change.
- key_up held 31 cycles -> events at edges 0, 20, 25, 30; count_to = 3432; release -> FSM IDLE, count_to stable.
- key_down held until saturation from 6934 -> 6944, at_max = 1, further repeats leave 6944. key_up held from 1742 -> 1736, at_min = 1.
- key_up held, then key_down asserted -> no more events; key_down released while key_up still held -> still no events until both low, then a fresh key_up press gives one event.
- count_to = 3472 with div_cnt = 3000, key_reset/other logic sets count_to = 2000 -> sample_tick on next edge, then every 2000 cycles. key_reset during REPEAT -> count_to = 3472 next edge, FSM BLOCKED.
